// File: rtl/codes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : codes (package)
// Description : Shared encodings for the MIPS bus arbiter: arbiter FSM
//               states and requester identifiers.
// Revision    : 1.0 - initial release
// ============================================================================
package codes;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IF = 2'd1,
    GRANT_D  = 2'd2
  } arb_state_t;

  // Requester identity, used for the last-served record
  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } requester_t;

endpackage
`default_nettype wire

// File: rtl/mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mips_bus_arbiter
// Description : Arbitrates an instruction-fetch port and a data port onto a
//               single Avalon-MM master. One transaction at a time; every
//               grant is preceded by one IDLE arbitration cycle.
// Revision    : 1.0 - initial release
//
// Parameters  : FAIR    - 1 = round-robin on ties, 0 = data port always wins
//               TIMEOUT - stalled granted cycles before the sticky timeout
// Ports       : clk, reset (async, active-low)
//               if_*    - fetch requester (read only)
//               d_*     - data requester (read / write)
//               address, read, write, writedata, byteenable, waitrequest,
//               readdata - Avalon master side
//               timeout - sticky flag, set once a grant stalls TIMEOUT cycles
// ============================================================================
module mips_bus_arbiter
  import codes::*;
#(
  parameter int          FAIR    = 1,
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_read,
  input  logic [31:0] if_address,
  output logic [31:0] if_readdata,
  output logic        if_waitrequest,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_address,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic [31:0] d_readdata,
  output logic        d_waitrequest,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        timeout
);

  arb_state_t  state, state_next;
  requester_t  last_served, last_next;
  logic [15:0] wait_cnt;
  logic        if_req, d_req;
  logic        granted_req;
  logic        stall_cycle;

  assign if_req = if_read;
  assign d_req  = d_read | d_write;

  // Read data is shared; each requester only samples it at its completion.
  assign if_readdata = readdata;
  assign d_readdata  = readdata;

  // Whether the currently granted requester is still asking for the bus.
  assign granted_req = (state == GRANT_IF) ? if_req :
                       (state == GRANT_D)  ? d_req  : 1'b0;
  assign stall_cycle = granted_req & waitrequest;

  always_comb begin
    state_next     = state;
    last_next      = last_served;
    read           = 1'b0;
    write          = 1'b0;
    address        = 32'd0;
    writedata      = 32'd0;
    byteenable     = 4'd0;
    if_waitrequest = 1'b1;
    d_waitrequest  = 1'b1;

    case (state)
      IDLE: begin
        if (if_req && d_req) begin
          // Tie: fixed priority favours data; round-robin favours whoever
          // was not served last.
          if ((FAIR == 0) || (last_served == REQ_IF)) state_next = GRANT_D;
          else                                        state_next = GRANT_IF;
        end else if (d_req) begin
          state_next = GRANT_D;
        end else if (if_req) begin
          state_next = GRANT_IF;
        end
      end

      GRANT_IF: begin
        read       = if_read;
        address    = if_address;
        byteenable = 4'hF;
        if (!if_req) begin
          // Requester withdrew: abandon without completion.
          state_next = IDLE;
        end else if (!waitrequest) begin
          if_waitrequest = 1'b0;
          state_next     = IDLE;
          last_next      = REQ_IF;
        end
      end

      GRANT_D: begin
        // A simultaneous read and write forwards only the write.
        write      = d_write;
        read       = d_read & ~d_write;
        address    = d_address;
        writedata  = d_writedata;
        byteenable = d_byteenable;
        if (!d_req) begin
          state_next = IDLE;
        end else if (!waitrequest) begin
          d_waitrequest = 1'b0;
          state_next    = IDLE;
          last_next     = REQ_D;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_served <= REQ_IF;
      wait_cnt    <= 16'd0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_next;
      last_served <= last_next;
      // Every grant is entered from IDLE, so clearing there clears on entry.
      if (state == IDLE) begin
        wait_cnt <= 16'd0;
      end else if (stall_cycle && (wait_cnt != 16'hFFFF)) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
      if (stall_cycle && ((wait_cnt + 16'd1) >= TIMEOUT)) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_bus_arbiter
// Description : Self-checking bench for mips_bus_arbiter. Two instances share
//               all inputs: "a" (FAIR=1, TIMEOUT=4) and "b" (FAIR=0, default
//               TIMEOUT). A transaction-level reference model predicts both.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        if_read;
  logic [31:0] if_address;
  logic        d_read, d_write;
  logic [31:0] d_address, d_writedata;
  logic [3:0]  d_byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  logic [31:0] a_if_rd, a_d_rd, a_address, a_writedata;
  logic        a_ifw, a_dw, a_read, a_write, a_timeout;
  logic [3:0]  a_be;
  logic [31:0] b_if_rd, b_d_rd, b_address, b_writedata;
  logic        b_ifw, b_dw, b_read, b_write, b_timeout;
  logic [3:0]  b_be;

  int passed = 0;
  int total  = 0;

  mips_bus_arbiter #(.FAIR(1), .TIMEOUT(16'd4)) dut_a (
    .clk(clk), .reset(reset),
    .if_read(if_read), .if_address(if_address),
    .if_readdata(a_if_rd), .if_waitrequest(a_ifw),
    .d_read(d_read), .d_write(d_write), .d_address(d_address),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable),
    .d_readdata(a_d_rd), .d_waitrequest(a_dw),
    .address(a_address), .read(a_read), .write(a_write),
    .writedata(a_writedata), .byteenable(a_be),
    .waitrequest(waitrequest), .readdata(readdata), .timeout(a_timeout)
  );

  mips_bus_arbiter #(.FAIR(0)) dut_b (
    .clk(clk), .reset(reset),
    .if_read(if_read), .if_address(if_address),
    .if_readdata(b_if_rd), .if_waitrequest(b_ifw),
    .d_read(d_read), .d_write(d_write), .d_address(d_address),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable),
    .d_readdata(b_d_rd), .d_waitrequest(b_dw),
    .address(b_address), .read(b_read), .write(b_write),
    .writedata(b_writedata), .byteenable(b_be),
    .waitrequest(waitrequest), .readdata(readdata), .timeout(b_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Per instance k (0 = a, 1 = b): owner of the bus (0 none, 1 IF, 2 D),
  // last served (1 IF, 2 D), stalled cycles in this grant, sticky timeout.
  int mg[2];
  int ml[2];
  int ms[2];
  bit mt[2];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        mg[k] <= 0; ml[k] <= 1; ms[k] <= 0; mt[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        automatic int g = mg[k];
        automatic int l = ml[k];
        automatic int s = ms[k];
        automatic bit t = mt[k];
        automatic bit ia = if_read;
        automatic bit da = d_read | d_write;
        automatic int lim = (k == 0) ? 4 : 1024;
        if (g == 0) begin
          s = 0;
          if (ia && da)  g = (k == 1) ? 2 : ((l == 1) ? 2 : 1);
          else if (da)   g = 2;
          else if (ia)   g = 1;
        end else if (!((g == 1) ? ia : da)) begin
          g = 0;
        end else if (!waitrequest) begin
          l = g; g = 0;
        end else begin
          if (s < 65535) s++;
          if (s >= lim) t = 1'b1;
        end
        mg[k] <= g; ml[k] <= l; ms[k] <= s; mt[k] <= t;
      end
    end
  end

  // Expected {read, write, address, writedata, byteenable, if_wait, d_wait, timeout}
  function automatic logic [73:0] exp_out(input int k);
    logic rd = 1'b0, wr = 1'b0, ifw = 1'b1, dw = 1'b1;
    logic [31:0] ad = 32'd0, wd = 32'd0;
    logic [3:0]  be = 4'd0;
    if (mg[k] == 1) begin
      rd = if_read; ad = if_address; be = 4'hF;
      if (if_read && !waitrequest) ifw = 1'b0;
    end else if (mg[k] == 2) begin
      wr = d_write; rd = d_read && !d_write;
      ad = d_address; wd = d_writedata; be = d_byteenable;
      if ((d_read || d_write) && !waitrequest) dw = 1'b0;
    end
    return {rd, wr, ad, wd, be, ifw, dw, mt[k]};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_inputs();
    if_read = 1'b0; if_address = 32'd0;
    d_read = 1'b0; d_write = 1'b0; d_address = 32'd0;
    d_writedata = 32'd0; d_byteenable = 4'd0;
    waitrequest = 1'b0; readdata = 32'd0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    @(negedge clk);
    total++; if ({a_read, a_write} !== 2'b00) $display("FAIL reset_rw: got %b want 00", {a_read, a_write}); else passed++;
    total++; if ({a_address, a_writedata, a_be} !== 68'd0) $display("FAIL reset_bus: got %h want 0", {a_address, a_writedata, a_be}); else passed++;
    total++; if ({a_ifw, a_dw, a_timeout} !== 3'b110) $display("FAIL reset_wait: got %b want 110", {a_ifw, a_dw, a_timeout}); else passed++;
    total++; if ({b_ifw, b_dw, b_read, b_write} !== 4'b1100) $display("FAIL reset_b: got %b want 1100", {b_ifw, b_dw, b_read, b_write}); else passed++;
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_fetch();
    apply_reset();
    if_read = 1'b1; if_address = 32'hBFC00000; readdata = 32'h0123ABCD;
    @(negedge clk);
    total++; if ({a_read, a_ifw} !== 2'b01) $display("FAIL fetch_bubble: got %b want 01", {a_read, a_ifw}); else passed++;
    next_cycle();
    @(negedge clk);
    total++; if (a_read !== 1'b1 || a_address !== 32'hBFC00000) $display("FAIL fetch_bus: got %b %h want 1 bfc00000", a_read, a_address); else passed++;
    total++; if ({a_write, a_be, a_ifw, a_dw} !== 7'b0_1111_0_1) $display("FAIL fetch_ctl: got %b want 0111101", {a_write, a_be, a_ifw, a_dw}); else passed++;
    total++; if (a_if_rd !== 32'h0123ABCD) $display("FAIL fetch_rdata: got %h want 0123abcd", a_if_rd); else passed++;
    next_cycle();
    if_read = 1'b0;
    @(negedge clk);
    total++; if ({a_read, a_ifw} !== 2'b01) $display("FAIL fetch_done: got %b want 01", {a_read, a_ifw}); else passed++;
  endtask

  task automatic test_tie();
    apply_reset();
    if_read = 1'b1; if_address = 32'h00400000;
    d_write = 1'b1; d_address = 32'h1000; d_writedata = 32'hDEADBEEF; d_byteenable = 4'h3;
    next_cycle();
    @(negedge clk);
    total++; if ({a_write, a_read, a_be} !== 6'b10_0011) $display("FAIL tie_d_ctl: got %b want 100011", {a_write, a_read, a_be}); else passed++;
    total++; if (a_address !== 32'h1000 || a_writedata !== 32'hDEADBEEF) $display("FAIL tie_d_bus: got %h %h want 1000 deadbeef", a_address, a_writedata); else passed++;
    total++; if ({a_dw, a_ifw} !== 2'b01) $display("FAIL tie_d_wait: got %b want 01", {a_dw, a_ifw}); else passed++;
    next_cycle();
    d_write = 1'b0;
    @(negedge clk);
    total++; if ({a_read, a_write} !== 2'b00) $display("FAIL tie_bubble: got %b want 00", {a_read, a_write}); else passed++;
    next_cycle();
    @(negedge clk);
    total++; if ({a_read, a_ifw} !== 2'b10 || a_address !== 32'h00400000) $display("FAIL tie_if: got %b %h want 10 00400000", {a_read, a_ifw}, a_address); else passed++;
    next_cycle();
    if_read = 1'b0;
  endtask

  task automatic test_fixed_priority();
    int a_d = 0, a_i = 0, b_d = 0, b_i = 0;
    apply_reset();
    if_read = 1'b1; d_read = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (!a_dw)  a_d++;
      if (!a_ifw) a_i++;
      if (!b_dw)  b_d++;
      if (!b_ifw) b_i++;
      next_cycle();
    end
    clear_inputs();
    total++; if (b_d !== 6 || b_i !== 0) $display("FAIL fixed_counts: got d=%0d if=%0d want d=6 if=0", b_d, b_i); else passed++;
    total++; if (a_d !== 3 || a_i !== 3) $display("FAIL rr_counts: got d=%0d if=%0d want d=3 if=3", a_d, a_i); else passed++;
  endtask

  task automatic test_stall();
    apply_reset();
    if_read = 1'b1; d_read = 1'b1; d_address = 32'h2000_0040; waitrequest = 1'b1;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      waitrequest = (i < 5);
      @(negedge clk);
      total++;
      if ({a_read, a_address, a_dw, a_ifw} !== {1'b1, 32'h2000_0040, (i != 5), 1'b1})
        $display("FAIL stall_cycle%0d: got %b %h %b%b want 1 20000040 %b1", i + 1, a_read, a_address, a_dw, a_ifw, (i != 5));
      else passed++;
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_timeout();
    apply_reset();
    d_read = 1'b1; waitrequest = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      next_cycle();
      @(negedge clk);
      total++;
      if (a_timeout !== (i == 5)) $display("FAIL timeout_grant%0d: got %b want %b", i, a_timeout, (i == 5)); else passed++;
    end
    next_cycle();
    waitrequest = 1'b0;
    @(negedge clk);
    total++; if ({a_dw, a_timeout} !== 2'b01) $display("FAIL timeout_complete: got %b want 01", {a_dw, a_timeout}); else passed++;
    next_cycle();
    d_read = 1'b0;
    repeat (2) next_cycle();
    total++; if (a_timeout !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", a_timeout); else passed++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    d_read = 1'b1; d_address = 32'h0000_0100; waitrequest = 1'b1;
    repeat (5) next_cycle();
    total++; if ({a_read, a_timeout} !== 2'b11) $display("FAIL mid_pre: got %b want 11", {a_read, a_timeout}); else passed++;
    reset = 1'b0;
    #1;
    total++; if ({a_read, a_dw, a_timeout} !== 3'b010) $display("FAIL mid_abort: got %b want 010", {a_read, a_dw, a_timeout}); else passed++;
    @(posedge clk);
    #1 reset = 1'b1; waitrequest = 1'b0;
    @(negedge clk);
    total++; if ({a_read, a_dw} !== 2'b01) $display("FAIL mid_bubble: got %b want 01", {a_read, a_dw}); else passed++;
    next_cycle();
    @(negedge clk);
    total++; if ({a_read, a_dw, a_timeout} !== 3'b100) $display("FAIL mid_complete: got %b want 100", {a_read, a_dw, a_timeout}); else passed++;
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_random();
    logic [73:0] ea, eb;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      if_read      = ($urandom_range(0, 9) < 6);
      d_read       = ($urandom_range(0, 9) < 5);
      d_write      = ($urandom_range(0, 9) < 3);
      if_address   = $urandom;
      d_address    = $urandom;
      d_writedata  = $urandom;
      d_byteenable = 4'($urandom);
      waitrequest  = ($urandom_range(0, 9) < 4);
      readdata     = $urandom;
      @(negedge clk);
      ea = exp_out(0);
      eb = exp_out(1);
      total++;
      if ({a_read, a_write, a_address, a_writedata, a_be, a_ifw, a_dw, a_timeout} !== ea)
        $display("FAIL rand_a cyc%0d: got %h want %h", c, {a_read, a_write, a_address, a_writedata, a_be, a_ifw, a_dw, a_timeout}, ea);
      else passed++;
      total++;
      if ({b_read, b_write, b_address, b_writedata, b_be, b_ifw, b_dw, b_timeout} !== eb)
        $display("FAIL rand_b cyc%0d: got %h want %h", c, {b_read, b_write, b_address, b_writedata, b_be, b_ifw, b_dw, b_timeout}, eb);
      else passed++;
      total++;
      if ({a_if_rd, a_d_rd, b_if_rd, b_d_rd} !== {4{readdata}})
        $display("FAIL rand_rdata cyc%0d: got %h %h want %h", c, a_if_rd, a_d_rd, readdata);
      else passed++;
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    test_reset();
    test_fetch();
    test_tie();
    test_fixed_priority();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
